// File: rtl/pend_encoder_rr_pkg.sv
// Shared constants and helpers for the pending-request encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pend_encoder_rr_pkg;

  localparam int PEND_ENC_N_DEF = 64;
  localparam int PEND_ENC_W_DEF = 6;

  // Binary index of a one-hot vector; all-zero input yields 0.
  // Sized for the largest legal N; narrower vectors are zero-extended by callers.
  function automatic logic [PEND_ENC_W_DEF-1:0] onehot_to_idx(
    input logic [PEND_ENC_N_DEF-1:0] oh
  );
    logic [PEND_ENC_W_DEF-1:0] idx;
    idx = '0;
    for (int i = 0; i < PEND_ENC_N_DEF; i++) begin
      if (oh[i]) idx = idx | PEND_ENC_W_DEF'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pend_encoder_rr_rot_prio_enc.sv
// Rotating priority encoder: first set bit at or after start, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; no handshake at this level.
module rot_prio_enc
  import pend_encoder_rr_pkg::*;
#(
  parameter int N = PEND_ENC_N_DEF,
  parameter int W = PEND_ENC_W_DEF
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [N-1:0] iso;
  logic [W-1:0] ffs;

  // Rotate so that bit 'start' lands at position 0, isolate the lowest set bit,
  // then add the rotation back; W-bit wrap is the modulo-N since N = 2**W.
  always_comb begin
    rot   = (vec >> start) | (vec << (N - int'(start)));
    iso   = rot & (-rot);
    ffs   = W'(onehot_to_idx(PEND_ENC_N_DEF'(iso)));
    found = |vec;
    idx   = ffs + start;
  end

endmodule

// File: rtl/pend_encoder_rr.sv
// Accumulates request pulses into a pending set and grants one source index per handshake.
// Latency: set_vec[i] at cycle 0 with an idle output gives out_valid/out_idx at cycle 2.
// Backpressure: out_idx held while out_valid & !out_ready; PEND_ENC_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module pend_encoder_rr
  import pend_encoder_rr_pkg::*;
#(
  parameter int N = PEND_ENC_N_DEF,  // 4, 16, 32 or 64
  parameter int W = PEND_ENC_W_DEF   // log2(N)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] set_vec,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic         pend_any
);

  logic [N-1:0] pend;
  logic [N-1:0] idx_oh;
  logic [N-1:0] clr;
  logic [N-1:0] hold;
  logic [N-1:0] avail;
  logic         fire;
  logic         sel_found;
  logic [W-1:0] sel;
  logic [W-1:0] start;

  // The granted bit stays in pend until it fires, so it must be masked from
  // selection while held to avoid granting the same source twice.
  always_comb begin
    fire   = out_valid & out_ready;
    idx_oh = N'(1) << out_idx;
    clr    = fire ? idx_oh : '0;
    hold   = out_valid ? idx_oh : '0;
    avail  = pend & ~clr & ~hold;
  end

  assign pend_any = |pend;

`ifdef PEND_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  // Search start moves one past the last fired index; flush leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (!flush && fire) begin
      ptr <= out_idx + W'(1);
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  rot_prio_enc #(
    .N (N),
    .W (W)
  ) u_rot_prio_enc (
    .vec   (avail),
    .start (start),
    .found (sel_found),
    .idx   (sel)
  );

  // Pending set: new requests win over the fire-clear on the same bit (re-queue);
  // flush drops everything except requests arriving in the flush cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= '0;
    end else if (flush) begin
      pend <= set_vec;
    end else begin
      pend <= (pend & ~clr) | set_vec;
    end
  end

  // Output register reloads only when empty or consumed; idx keeps its last
  // value when nothing is available so it never glitches under valid=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || fire) begin
      out_valid <= sel_found;
      if (sel_found) out_idx <= sel;
    end
  end

endmodule

// File: tb/tb_pend_encoder_rr.sv
module tb_pend_encoder_rr;

  logic        clk;
  logic        resetn;
  logic [63:0] set_vec;
  logic        flush;
  logic        out_valid;
  logic [5:0]  out_idx;
  logic        out_ready;
  logic        pend_any;

  int nvec = 0;
  int nerr = 0;

  pend_encoder_rr #(.N(64), .W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .set_vec   (set_vec),
    .flush     (flush),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .pend_any  (pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; set_vec = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    nvec++;
    if (out_valid !== 1'b0 || out_idx !== 6'd0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: valid=%0b idx=%0d pend_any=%0b, required 0/0/0", out_valid, out_idx, pend_any);
    end
    #3 resetn = 1'b1;
    tick();
    set_vec = 64'h0000_0000_0000_0F00;
    tick();
    set_vec = '0;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd8 || pend_any !== 1'b1) begin
      nerr++;
      $display("FAIL reset_pre_grant: valid=%0b idx=%0d pend_any=%0b, required 1/8/1", out_valid, out_idx, pend_any);
    end
    #2 resetn = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_idx !== 6'd0 || pend_any !== 1'b0 || dut.pend !== 64'h0) begin
      nerr++;
      $display("FAIL reset_async: valid=%0b idx=%0d pend_any=%0b pend=%h, required 0/0/0/0", out_valid, out_idx, pend_any, dut.pend);
    end
    tick(); tick();
    #2 resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
        nerr++;
        $display("FAIL reset_idle_c%0d: valid=%0b pend_any=%0b, required 0/0", c, out_valid, pend_any);
      end
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_vec = 64'h1 << 37;
    tick();
    set_vec = '0;
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b1) begin
      nerr++;
      $display("FAIL single_c1: valid=%0b pend_any=%0b, required 0/1", out_valid, pend_any);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd37) begin
      nerr++;
      $display("FAIL single_c2: valid=%0b idx=%0d, required 1/37", out_valid, out_idx);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL single_c3: valid=%0b pend_any=%0b, required 0/0", out_valid, pend_any);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_vec = (64'h1 << 3) | (64'h1 << 9);
    tick();
    set_vec = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== 6'd3) begin
        nerr++;
        $display("FAIL bp_hold_c%0d: valid=%0b idx=%0d, required 1/3", c, out_valid, out_idx);
      end
      if (c < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd9) begin
      nerr++;
      $display("FAIL bp_second: valid=%0b idx=%0d, required 1/9", out_valid, out_idx);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drain: valid=%0b pend_any=%0b, required 0/0", out_valid, pend_any);
    end
  endtask

  task automatic test_rr_wrap();
    logic [5:0] exp_order [3];
`ifdef PEND_ENC_ROUND_ROBIN_EN
    exp_order[0] = 6'd63; exp_order[1] = 6'd0;  exp_order[2] = 6'd61;
`else
    exp_order[0] = 6'd0;  exp_order[1] = 6'd61; exp_order[2] = 6'd63;
`endif
    out_ready = 1'b1;
    set_vec = 64'h1 << 62;
    tick();
    set_vec = '0;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd62) begin
      nerr++;
      $display("FAIL rr_first62: valid=%0b idx=%0d, required 1/62", out_valid, out_idx);
    end
    tick();
    set_vec = (64'h1 << 0) | (64'h1 << 61) | (64'h1 << 63);
    tick();
    set_vec = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_idx !== exp_order[k]) begin
        nerr++;
        $display("FAIL rr_order_%0d: valid=%0b idx=%0d, required 1/%0d", k, out_valid, out_idx, exp_order[k]);
      end
      tick();
    end
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL rr_drain: valid=%0b pend_any=%0b, required 0/0", out_valid, pend_any);
    end
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    set_vec = 64'h1 << 5;
    tick();
    set_vec = '0;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd5) begin
      nerr++;
      $display("FAIL coll_grant: valid=%0b idx=%0d, required 1/5", out_valid, out_idx);
    end
    set_vec = 64'h1 << 5;
    tick();
    set_vec = '0;
    nvec++;
    if (out_valid !== 1'b0 || dut.pend[5] !== 1'b1 || pend_any !== 1'b1) begin
      nerr++;
      $display("FAIL coll_between: valid=%0b pend5=%0b pend_any=%0b, required 0/1/1", out_valid, dut.pend[5], pend_any);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd5) begin
      nerr++;
      $display("FAIL coll_regrant: valid=%0b idx=%0d, required 1/5", out_valid, out_idx);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL coll_drain: valid=%0b pend_any=%0b, required 0/0", out_valid, pend_any);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_vec = (64'h1 << 2) | (64'h1 << 4);
    tick();
    set_vec = '0;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd2 || dut.pend !== 64'h14) begin
      nerr++;
      $display("FAIL flush_pre: valid=%0b idx=%0d pend=%h, required 1/2/14", out_valid, out_idx, dut.pend);
    end
    flush = 1'b1;
    set_vec = 64'h1 << 7;
    tick();
    flush = 1'b0;
    set_vec = '0;
    nvec++;
    if (out_valid !== 1'b0 || dut.pend !== 64'h80) begin
      nerr++;
      $display("FAIL flush_after: valid=%0b pend=%h, required 0/80", out_valid, dut.pend);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== 6'd7) begin
      nerr++;
      $display("FAIL flush_regrant: valid=%0b idx=%0d, required 1/7", out_valid, out_idx);
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) begin
      nerr++;
      $display("FAIL flush_drain: valid=%0b pend_any=%0b, required 0/0", out_valid, pend_any);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_rr_wrap();
    test_collision();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
